// File: rtl/punc_pkg.sv
// punc_pkg: shared opcodes, FSM states, NZP encodings and helpers for the PUnC core.
package punc_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

    localparam logic [7:0] TRAP_HALT = 8'h25;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        return v[15] ? NZP_N : (v == 16'd0) ? NZP_Z : NZP_P;
    endfunction

endpackage

// File: rtl/punc_regfile.sv
// punc_regfile: 8x16 register file, two operand read ports, a debug read port, one write port.
module punc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [2:0]  raddr_a,
    input  logic [2:0]  raddr_b,
    output logic [15:0] rdata_a,
    output logic [15:0] rdata_b,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);
    logic [15:0] r [8];

    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < 8; i++) r[i] <= '0;
        else if (we)
            r[waddr] <= wdata;

    assign rdata_a  = r[raddr_a];
    assign rdata_b  = r[raddr_b];
    assign dbg_data = r[dbg_addr];
endmodule

// File: rtl/punc_mc_core.sv
// punc_mc_core: multicycle LC3-subset core with step mode, halt flag and retire counter.
module punc_mc_core
    import punc_pkg::*;
#(
    parameter int          ADDR_W        = 8,
    parameter logic [15:0] RESET_PC      = 16'h0000,
    parameter string       MEM_INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_mode,
    input  logic        step,
    output logic        halted,
    output logic [31:0] retired,
    input  logic [15:0] mem_debug_addr,
    input  logic [2:0]  rf_debug_addr,
    output logic [15:0] mem_debug_data,
    output logic [15:0] rf_debug_data,
    output logic [15:0] pc_debug_data
);
    localparam int DEPTH = 1 << ADDR_W;

    state_t      state, state_nx;
    logic [15:0] pc, ir, pc_nx, ra, rb, alu_b, alu, pc_off, ea, mem_ea, rf_wdata;
    logic [15:0] imm5, off6, off9;
    logic [15:0] mem [DEPTH];
    logic [2:0]  nzp;
    logic [3:0]  op;
    logic        hold, fetch_go, exec, in_mem, br_taken, pc_ld, rf_we, nzp_we, mem_we, retire;
    logic        is_alu, is_load, is_store, is_mem, is_halt, unused;

    assign op       = ir[15:12];
    assign imm5     = {{11{ir[4]}}, ir[4:0]};
    assign off6     = {{10{ir[5]}}, ir[5:0]};
    assign off9     = {{7{ir[8]}}, ir[8:0]};
    assign is_alu   = op == OP_ADD || op == OP_AND || op == OP_NOT;
    assign is_load  = op == OP_LD || op == OP_LDR;
    assign is_store = op == OP_ST || op == OP_STR;
    assign is_mem   = is_load || is_store;
    assign is_halt  = op == OP_TRAP && ir[7:0] == TRAP_HALT;

    punc_regfile u_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (ir[11:9]),
        .wdata    (rf_wdata),
        .raddr_a  (ir[8:6]),
        .raddr_b  (is_store ? ir[11:9] : ir[2:0]),
        .rdata_a  (ra),
        .rdata_b  (rb),
        .dbg_addr (rf_debug_addr),
        .dbg_data (rf_debug_data)
    );

    assign alu_b    = ir[5] ? imm5 : rb;
    assign alu      = op == OP_ADD ? ra + alu_b : op == OP_AND ? ra & alu_b : ~ra;
    assign pc_off   = pc + off9;
    assign ea       = (op == OP_LDR || op == OP_STR) ? ra + off6 : pc_off;
    assign mem_ea   = mem[ea[ADDR_W-1:0]];
    assign br_taken = op == OP_BR && |(ir[11:9] & nzp);
    assign hold     = step_mode && !step;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_FETCH;
        else     state <= state_nx;

    always_comb begin
        state_nx = state == S_FETCH  ? (hold ? S_FETCH : S_DECODE) :
                   state == S_DECODE ? S_EXEC :
                   state == S_EXEC   ? (is_halt ? S_HALT : is_mem ? S_MEM : S_FETCH) :
                   state == S_MEM    ? S_FETCH : S_HALT;
    end

    always_comb begin
        fetch_go = state == S_FETCH && !hold;
        exec     = state == S_EXEC;
        in_mem   = state == S_MEM;
        pc_ld    = fetch_go || (exec && (br_taken || op == OP_JMP));
        pc_nx    = fetch_go ? pc + 16'd1 : br_taken ? pc_off : ra;
        rf_we    = (exec && (is_alu || op == OP_LEA)) || (in_mem && is_load);
        rf_wdata = in_mem ? mem_ea : op == OP_LEA ? pc_off : alu;
        nzp_we   = (exec && is_alu) || (in_mem && is_load);
        mem_we   = in_mem && is_store;
        retire   = (exec && !is_mem) || in_mem;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            nzp     <= NZP_Z;
            retired <= '0;
        end else begin
            if (fetch_go) ir <= mem[pc[ADDR_W-1:0]];
            if (pc_ld) pc <= pc_nx;
            if (nzp_we) nzp <= nzp_of(rf_wdata);
            if (retire) retired <= retired + 32'd1;
        end

    always_ff @(posedge clk)
        if (mem_we) mem[ea[ADDR_W-1:0]] <= rb;

    assign halted         = state == S_HALT;
    assign pc_debug_data  = pc;
    assign mem_debug_data = mem[mem_debug_addr[ADDR_W-1:0]];
    assign unused         = ^{mem_debug_addr, ea};
endmodule

// File: tb/tb_punc_mc_core.sv
// tb_punc_mc_core: directed programs; a retire-driven monitor checks queued expectations.
module tb_punc_mc_core;
    localparam int K_NONE = 0, K_REG = 1, K_MEM = 2, K_NZP = 3, K_HALT = 4;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [31:0] ret;
        int          lat;
        int          kind;
        int          idx;
        logic [15:0] val;
    } exp_t;

    logic        clk = 0, rst = 1, step_mode = 0, step = 0;
    logic [15:0] mem_debug_addr = 0, mem_debug_data, rf_debug_data, pc_debug_data;
    logic [2:0]  rf_debug_addr = 0;
    logic        halted;
    logic [31:0] retired;
    logic [15:0] mem4_addr = 0, mem4_data, rf4_data, pc4_data;
    logic [2:0]  rf4_addr = 0;
    logic        halted4;
    logic [31:0] retired4;

    int          nchk = 0, nbad = 0, cyc = 0, last_cyc = 0, lat;
    logic [31:0] last_ret = 0;
    exp_t        q[$];
    exp_t        e;

    punc_mc_core dut (
        .clk(clk), .rst(rst), .step_mode(step_mode), .step(step),
        .halted(halted), .retired(retired),
        .mem_debug_addr(mem_debug_addr), .rf_debug_addr(rf_debug_addr),
        .mem_debug_data(mem_debug_data), .rf_debug_data(rf_debug_data),
        .pc_debug_data(pc_debug_data)
    );

    punc_mc_core #(.ADDR_W(4), .RESET_PC(16'h0010)) dut4 (
        .clk(clk), .rst(rst), .step_mode(step_mode), .step(step),
        .halted(halted4), .retired(retired4),
        .mem_debug_addr(mem4_addr), .rf_debug_addr(rf4_addr),
        .mem_debug_data(mem4_data), .rf_debug_data(rf4_data),
        .pc_debug_data(pc4_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic ex(input string n, input logic [15:0] p, input logic [31:0] r, input int l,
                      input int k, input int i, input logic [15:0] v);
        q.push_back(exp_t'{n, p, r, l, k, i, v});
    endtask

    // Every change of retired consumes one expectation; lat counts edges since the previous one.
    always @(negedge clk) begin
        if (rst) begin
            last_ret = 0;
            last_cyc = cyc;
        end else if (retired != last_ret) begin
            lat      = cyc - last_cyc;
            last_cyc = cyc;
            last_ret = retired;
            if (q.size() == 0) begin
                nchk++;
                nbad++;
                $display("FAIL unexpected_retire: got retired=%0d expected no retirement", retired);
            end else begin
                e = q.pop_front();
                chk({e.name, "_pc"}, 32'(pc_debug_data), 32'(e.pc));
                chk({e.name, "_retired"}, retired, e.ret);
                if (e.lat != 0) chk({e.name, "_cycles"}, lat, e.lat);
                if (e.kind == K_REG) begin
                    rf_debug_addr = 3'(e.idx);
                    #1 chk({e.name, "_reg"}, 32'(rf_debug_data), 32'(e.val));
                end else if (e.kind == K_MEM) begin
                    mem_debug_addr = 16'(e.idx);
                    #1 chk({e.name, "_mem"}, 32'(mem_debug_data), 32'(e.val));
                end else if (e.kind == K_NZP) begin
                    chk({e.name, "_nzp"}, 32'(dut.nzp), 32'(e.val));
                end else if (e.kind == K_HALT) begin
                    chk({e.name, "_halted"}, 32'(halted), 32'(e.val));
                end
            end
        end
    end

    task automatic start_reset();
        @(negedge clk);
        #1 rst = 1;
        for (int i = 0; i < 256; i++) dut.mem[8'(i)] <= 16'h0000;
    endtask

    task automatic put(input logic [7:0] a, input logic [15:0] v);
        dut.mem[a] <= v;
    endtask

    task automatic release_rst();
        repeat (2) @(negedge clk);
        #1 rst = 0;
    endtask

    task automatic wait_halt(input string n, input int budget);
        int k;
        k = 0;
        while (!halted && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({n, "_halt_reached"}, 32'(halted), 32'd1);
        @(negedge clk);
        #3 chk({n, "_queue_drained"}, q.size(), 0);
    endtask

    task automatic regs_zero(input string n);
        for (int i = 0; i < 8; i++) begin
            rf_debug_addr = 3'(i);
            #1 chk($sformatf("%s_r%0d", n, i), 32'(rf_debug_data), 32'd0);
        end
    endtask

    initial begin
        // Program A plus the aliasing program for the ADDR_W=4 core.
        start_reset();
        put(0, 16'h1265); put(1, 16'hF025);
        for (int i = 0; i < 16; i++) dut4.mem[4'(i)] <= 16'h0000;
        dut4.mem[0] <= 16'h1269;
        dut4.mem[1] <= 16'h3201;
        dut4.mem[2] <= 16'hF025;
        @(negedge clk);
        #2 chk("rst_pc", 32'(pc_debug_data), 32'h0000);
        chk("rst_retired", retired, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_nzp", 32'(dut.nzp), 32'b010);
        chk("rst_pc_vector", 32'(pc4_data), 32'h0010);
        regs_zero("rst");
        ex("a_add", 16'd1, 1, 3, K_REG, 1, 16'd5);
        ex("a_halt", 16'd2, 2, 3, K_HALT, 0, 16'd1);
        release_rst();
        wait_halt("prog_a", 20);
        chk("a_nzp", 32'(dut.nzp), 32'b001);
        chk("a_pc_hold", 32'(pc_debug_data), 32'd2);

        // Program B: overflow to negative, then branch conditions.
        start_reset();
        put(0, 16'h200F); put(1, 16'h1021); put(2, 16'h0801); put(3, 16'h1B61);
        put(4, 16'h0401); put(5, 16'h1DA1); put(6, 16'h0E01); put(7, 16'h1B61);
        put(8, 16'h0001); put(9, 16'hF025); put(16, 16'h7FFF);
        ex("b_ld", 16'd1, 1, 4, K_REG, 0, 16'h7FFF);
        ex("b_add_ovf", 16'd2, 2, 3, K_REG, 0, 16'h8000);
        ex("b_brn_taken", 16'd4, 3, 3, K_NZP, 0, 16'b100);
        ex("b_brz_not", 16'd5, 4, 3, K_NONE, 0, 0);
        ex("b_add_pos", 16'd6, 5, 3, K_REG, 6, 16'd1);
        ex("b_brnzp", 16'd8, 6, 3, K_NZP, 0, 16'b001);
        ex("b_br000", 16'd9, 7, 3, K_NONE, 0, 0);
        ex("b_halt", 16'd10, 8, 3, K_REG, 5, 16'd0);
        release_rst();
        wait_halt("prog_b", 60);

        chk("alias_halted", 32'(halted4), 1);
        chk("alias_pc", 32'(pc4_data), 32'h0013);
        chk("alias_retired", retired4, 3);
        rf4_addr = 3'd1;
        mem4_addr = 16'h0003;
        #1 chk("alias_r1", 32'(rf4_data), 32'd9);
        chk("alias_mem_0003", 32'(mem4_data), 32'd9);
        mem4_addr = 16'h0013;
        #1 chk("alias_mem_0013", 32'(mem4_data), 32'd9);

        // Program C: memory ops, logic ops, LEA, JMP, NOP opcodes.
        start_reset();
        put(0, 16'h241F); put(1, 16'hE804); put(2, 16'h3403); put(3, 16'h6700);
        put(4, 16'h0E02); put(5, 16'h1B61); put(7, 16'h770F); put(8, 16'h9EFF);
        put(9, 16'h53C3); put(10, 16'h52FF); put(11, 16'h1247); put(12, 16'hE002);
        put(13, 16'hC000); put(14, 16'h1B61); put(15, 16'hF023); put(16, 16'h8000);
        put(17, 16'hF025); put(32, 16'hBEEF);
        ex("c_ld", 16'd1, 1, 4, K_REG, 2, 16'hBEEF);
        ex("c_lea_keeps_nzp", 16'd2, 2, 3, K_NZP, 0, 16'b100);
        ex("c_st", 16'd3, 3, 4, K_MEM, 6, 16'hBEEF);
        ex("c_ldr", 16'd4, 4, 4, K_REG, 3, 16'hBEEF);
        ex("c_br", 16'd7, 5, 3, K_NONE, 0, 0);
        ex("c_str", 16'd8, 6, 4, K_MEM, 21, 16'hBEEF);
        ex("c_not", 16'd9, 7, 3, K_REG, 7, 16'h4110);
        ex("c_and_reg", 16'd10, 8, 3, K_NZP, 0, 16'b010);
        ex("c_and_imm", 16'd11, 9, 3, K_REG, 1, 16'hBEEF);
        ex("c_add_reg", 16'd12, 10, 3, K_REG, 1, 16'hFFFF);
        ex("c_lea", 16'd13, 11, 3, K_REG, 0, 16'h000F);
        ex("c_jmp", 16'd15, 12, 3, K_NONE, 0, 0);
        ex("c_trap_nop", 16'd16, 13, 3, K_NONE, 0, 0);
        ex("c_op_nop", 16'd17, 14, 3, K_NONE, 0, 0);
        ex("c_halt", 16'd18, 15, 3, K_REG, 5, 16'd0);
        release_rst();
        wait_halt("prog_c", 80);

        // Step mode: nothing moves without a pulse; a pulse outside FETCH is dropped.
        start_reset();
        put(0, 16'h1265); put(1, 16'h1265); put(2, 16'hF025);
        step_mode = 1;
        release_rst();
        repeat (20) @(negedge clk);
        #2 chk("step_idle_pc", 32'(pc_debug_data), 32'd0);
        chk("step_idle_retired", retired, 0);
        ex("step_one", 16'd1, 1, 0, K_REG, 1, 16'd5);
        @(negedge clk);
        #1 step = 1;
        @(negedge clk);
        #1 step = 0;
        @(negedge clk);
        #1 step = 1;
        @(negedge clk);
        #1 step = 0;
        repeat (20) @(negedge clk);
        #2 chk("step_after_pc", 32'(pc_debug_data), 32'd1);
        chk("step_after_retired", retired, 1);
        ex("step_run", 16'd2, 2, 0, K_REG, 1, 16'd10);
        ex("step_halt", 16'd3, 3, 3, K_HALT, 0, 16'd1);
        step_mode = 0;
        wait_halt("step_free", 30);

        // Reset during the MEM state of a store.
        start_reset();
        put(0, 16'h14A7); put(1, 16'h3405); put(7, 16'h1111);
        ex("rm_add", 16'd1, 1, 3, K_REG, 2, 16'd7);
        release_rst();
        repeat (6) @(posedge clk);
        #2 rst = 1;
        @(negedge clk);
        mem_debug_addr = 16'd7;
        #2 chk("rm_mem_kept", 32'(mem_debug_data), 32'h1111);
        chk("rm_pc", 32'(pc_debug_data), 32'd0);
        chk("rm_retired", retired, 0);
        chk("rm_halted", 32'(halted), 0);
        chk("rm_queue", q.size(), 0);
        regs_zero("rm");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
